// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU self-test controller: opcodes, FSM states,
// LFSR tap mask and the golden ALU function.
package alu_bist_pkg;

   localparam int MAX_WIDTH = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   // Bits 15,13,12,10 of the shift register correspond to taps 16,14,13,11.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRIVE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Computed at full width; callers keep the low WIDTH bits, which equals mod 2^WIDTH.
   function automatic logic [MAX_WIDTH-1:0] alu_ref(input logic [MAX_WIDTH-1:0] a,
                                                   input logic [MAX_WIDTH-1:0] b,
                                                   input logic [1:0]           op);
      logic [MAX_WIDTH-1:0] r;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_AND:  r = a & b;
         default: r = a | b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 16-bit Fibonacci shift register, left-shifting with feedback into bit 0.
// With MISR=1 each advance also XORs din into the shifted value (signature mode).
module alu_bist_lfsr
   import alu_bist_pkg::*;
#(
   parameter logic [15:0] RST_VAL = 16'hACE1,
   parameter bit          MISR    = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        adv,
   input  logic [15:0] din,
   output logic [15:0] state
);

   logic [15:0] state_q, state_d;
   logic [15:0] shifted;
   logic        fb;

   always_comb begin
      fb      = ^(state_q & LFSR_TAPS);
      shifted = {state_q[14:0], fb};
      state_d = state_q;
      if (load) begin
         state_d = RST_VAL;
      end else if (adv) begin
         state_d = MISR ? (shifted ^ din) : shifted;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_VAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU self-test engine: drives corner and LFSR vectors for each opcode and checks Y.
// Optional MISR signature over all sampled Y values is built when ALU_BIST_MISR_EN is defined.
module alu_bist_ctrl
   import alu_bist_pkg::*;
#(
   parameter int          WIDTH = 8,
   parameter int          NVEC  = 16,
   parameter int          LAT   = 0,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [1:0]       OP,
   input  logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       err_cnt,
   output logic             fail_vld,
   output logic [1:0]       fail_op,
   output logic [WIDTH-1:0] fail_y,
   output logic [WIDTH-1:0] fail_exp,
   output logic [15:0]      signature
);

   localparam int VW = (NVEC > 1) ? $clog2(NVEC) : 1;
   localparam int WW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [VW-1:0] VEC_LAST  = VW'(NVEC - 1);
   localparam logic [WW-1:0] WAIT_LAST = (LAT > 0) ? WW'(LAT - 1) : '0;

   state_t           state_q, state_d;
   logic [1:0]       op_cnt_q, op_cnt_d;
   logic [VW-1:0]    vec_cnt_q, vec_cnt_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic             fail_vld_q, fail_vld_d;
   logic [1:0]       fail_op_q, fail_op_d;
   logic [WIDTH-1:0] fail_y_q, fail_y_d, fail_exp_q, fail_exp_d;

   logic                 start_acc, lfsr_adv;
   logic [15:0]          lfsr_val;
   logic [MAX_WIDTH-1:0] ref_full;
   logic [WIDTH-1:0]     exp_y;

   assign ref_full = alu_ref(MAX_WIDTH'(a_q), MAX_WIDTH'(b_q), op_q);
   assign exp_y    = ref_full[WIDTH-1:0];

   alu_bist_lfsr #(.RST_VAL(SEED), .MISR(1'b0)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start_acc),
      .adv   (lfsr_adv),
      .din   (16'h0000),
      .state (lfsr_val)
   );

   always_comb begin
      state_d    = state_q;
      op_cnt_d   = op_cnt_q;
      vec_cnt_d  = vec_cnt_q;
      wait_cnt_d = wait_cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      err_cnt_d  = err_cnt_q;
      fail_vld_d = fail_vld_q;
      fail_op_d  = fail_op_q;
      fail_y_d   = fail_y_q;
      fail_exp_d = fail_exp_q;
      start_acc  = 1'b0;
      lfsr_adv   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               start_acc  = 1'b1;
               state_d    = ST_DRIVE;
               op_cnt_d   = '0;
               vec_cnt_d  = '0;
               err_cnt_d  = '0;
               fail_vld_d = 1'b0;
               fail_op_d  = '0;
               fail_y_d   = '0;
               fail_exp_d = '0;
            end
         end

         ST_DRIVE: begin
            op_d       = op_cnt_q;
            wait_cnt_d = '0;
            // First vector of every opcode is the all-ones / one corner case.
            if (vec_cnt_q == '0) begin
               a_d = '1;
               b_d = WIDTH'(1);
            end else begin
               a_d      = lfsr_val[15 -: WIDTH];
               b_d      = lfsr_val[WIDTH-1:0];
               lfsr_adv = 1'b1;
            end
            state_d = (LAT > 0) ? ST_WAIT : ST_CHECK;
         end

         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = ST_CHECK;
            end else begin
               wait_cnt_d = wait_cnt_q + WW'(1);
            end
         end

         ST_CHECK: begin
            if (Y != exp_y) begin
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               if (!fail_vld_q) begin
                  fail_vld_d = 1'b1;
                  fail_op_d  = op_q;
                  fail_y_d   = Y;
                  fail_exp_d = exp_y;
               end
            end
            if (vec_cnt_q == VEC_LAST) begin
               vec_cnt_d = '0;
               if (op_cnt_q == OP_OR) begin
                  state_d = ST_DONE;
               end else begin
                  op_cnt_d = op_cnt_q + 2'd1;
                  state_d  = ST_DRIVE;
               end
            end else begin
               vec_cnt_d = vec_cnt_q + VW'(1);
               state_d   = ST_DRIVE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         op_cnt_q   <= '0;
         vec_cnt_q  <= '0;
         wait_cnt_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         err_cnt_q  <= '0;
         fail_vld_q <= 1'b0;
         fail_op_q  <= '0;
         fail_y_q   <= '0;
         fail_exp_q <= '0;
      end else begin
         state_q    <= state_d;
         op_cnt_q   <= op_cnt_d;
         vec_cnt_q  <= vec_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         err_cnt_q  <= err_cnt_d;
         fail_vld_q <= fail_vld_d;
         fail_op_q  <= fail_op_d;
         fail_y_q   <= fail_y_d;
         fail_exp_q <= fail_exp_d;
      end
   end

`ifdef ALU_BIST_MISR_EN
   logic [15:0] misr_val;

   // Only advances in CHECK, so the value naturally freezes once DONE is reached.
   alu_bist_lfsr #(.RST_VAL(16'h0000), .MISR(1'b1)) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start_acc),
      .adv   (state_q == ST_CHECK),
      .din   (16'(Y)),
      .state (misr_val)
   );
   assign signature = misr_val;
`else
   assign signature = '0;
`endif

   assign A        = a_q;
   assign B        = b_q;
   assign OP       = op_q;
   assign busy     = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
   assign done     = (state_q == ST_DONE);
   assign pass     = done && (err_cnt_q == 8'd0);
   assign err_cnt  = err_cnt_q;
   assign fail_vld = fail_vld_q;
   assign fail_op  = fail_op_q;
   assign fail_y   = fail_y_q;
   assign fail_exp = fail_exp_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: four controllers share clk/rst_n/start and drive a correct ALU,
// an OR->XOR faulty ALU, and a 2-stage registered ALU checked with LAT=2 and with LAT=0.
module tb_alu_bist_ctrl;

   localparam int NV     = 16;
   localparam int NDUT   = 4;
   localparam int BOUND  = 600;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst_n;
   logic start;

   logic [7:0]  a_w[NDUT], b_w[NDUT], y_w[NDUT], err_w[NDUT], fy_w[NDUT], fe_w[NDUT];
   logic [1:0]  op_w[NDUT], fop_w[NDUT];
   logic        busy_w[NDUT], done_w[NDUT], pass_w[NDUT], fvld_w[NDUT];
   logic [15:0] sig_w[NDUT];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] tb_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op, input bit or_is_xor);
      int s;
      case (op)
         2'd0:    s = int'(a) + int'(b);
         2'd1:    s = int'(a) - int'(b);
         2'd2:    s = int'(a & b);
         default: s = or_is_xor ? int'(a ^ b) : int'(a | b);
      endcase
      return 8'(s);
   endfunction

   // Taps 16,14,13,11 are register bits 15,13,12,10; new bit enters at bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[14:0], fb};
   endfunction

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      alu_bist_ctrl #(.WIDTH(8), .NVEC(NV), .LAT((gi == 2) ? 2 : 0), .SEED(SEED)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .A         (a_w[gi]),
         .B         (b_w[gi]),
         .OP        (op_w[gi]),
         .Y         (y_w[gi]),
         .busy      (busy_w[gi]),
         .done      (done_w[gi]),
         .pass      (pass_w[gi]),
         .err_cnt   (err_w[gi]),
         .fail_vld  (fvld_w[gi]),
         .fail_op   (fop_w[gi]),
         .fail_y    (fy_w[gi]),
         .fail_exp  (fe_w[gi]),
         .signature (sig_w[gi])
      );
      if (gi < 2) begin : g_comb
         assign y_w[gi] = tb_alu(a_w[gi], b_w[gi], op_w[gi], gi == 1);
      end else begin : g_pipe
         logic [7:0] p1, p2;
         always_ff @(posedge clk) begin
            p1 <= tb_alu(a_w[gi], b_w[gi], op_w[gi], 1'b0);
            p2 <= p1;
         end
         assign y_w[gi] = p2;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] op; } vec_t;
   typedef struct { bit pass; logic [7:0] err; logic [15:0] sig; } fin_t;

   vec_t vec_q[$];
   fin_t fin_q[$];

   int         xerr_exp;
   logic [1:0] xf_op;
   logic [7:0] xf_y, xf_exp;

   // Reference model: whole expected run for the correct ALU, plus the XOR-ALU outcome.
   task automatic push_model();
      logic [15:0] s, sig;
      vec_t        v;
      fin_t        f;
      logic [7:0]  yg, yx;
      bit          got_first;
      s = SEED; sig = 16'h0; got_first = 0; xerr_exp = 0;
      xf_op = 0; xf_y = 0; xf_exp = 0;
      for (int op = 0; op < 4; op++) begin
         for (int n = 0; n < NV; n++) begin
            v.op = 2'(op);
            if (n == 0) begin
               v.a = 8'hFF; v.b = 8'h01;
            end else begin
               v.a = s[15:8]; v.b = s[7:0];
               s = lfsr_step(s);
            end
            vec_q.push_back(v);
            yg = tb_alu(v.a, v.b, v.op, 1'b0);
            yx = tb_alu(v.a, v.b, v.op, 1'b1);
`ifdef ALU_BIST_MISR_EN
            sig = lfsr_step(sig) ^ {8'h00, yg};
`endif
            if (yx != yg) begin
               xerr_exp++;
               if (!got_first) begin
                  got_first = 1; xf_op = v.op; xf_y = yx; xf_exp = yg;
               end
            end
         end
      end
      f.pass = 1'b1; f.err = 8'h00; f.sig = sig;
      fin_q.push_back(f);
   endtask

   // Scoreboard monitor for the correct-ALU controller (LAT=0: vector i is checkable at busy cycle 2i+1).
   int mon_k, mon_idx;
   bit mon_run;
   initial begin
      vec_t e;
      fin_t f;
      mon_k = 0; mon_run = 0; mon_idx = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_k = 0; mon_run = 0; mon_idx = 0;
         end else if (busy_w[0]) begin
            if (!mon_run) begin
               mon_k = 0; mon_idx = 0;
            end
            mon_run = 1;
            if (mon_k % 2 == 1) begin
               if (vec_q.size() == 0) begin
                  chk("vec_queue_empty", 32'd0, 32'd1);
               end else begin
                  e = vec_q.pop_front();
                  $display("vec %0d: A=%02h B=%02h OP=%0d (exp %02h %02h %0d)",
                           mon_idx, a_w[0], b_w[0], op_w[0], e.a, e.b, e.op);
                  chk("vec_A", 32'(a_w[0]), 32'(e.a));
                  chk("vec_B", 32'(b_w[0]), 32'(e.b));
                  chk("vec_OP", 32'(op_w[0]), 32'(e.op));
               end
               mon_idx++;
            end
            mon_k++;
         end else if (mon_run) begin
            mon_run = 0;
            chk("run_len", 32'(mon_k), 32'(4 * NV * 2));
            if (fin_q.size() == 0) begin
               chk("fin_queue_empty", 32'd0, 32'd1);
            end else begin
               f = fin_q.pop_front();
               $display("run end: done=%0d pass=%0d err=%0d sig=%04h", done_w[0], pass_w[0], err_w[0], sig_w[0]);
               chk("fin_done", 32'(done_w[0]), 32'd1);
               chk("fin_pass", 32'(pass_w[0]), 32'(f.pass));
               chk("fin_err", 32'(err_w[0]), 32'(f.err));
               chk("fin_fail_vld", 32'(fvld_w[0]), 32'd0);
               chk("fin_sig", 32'(sig_w[0]), 32'(f.sig));
            end
         end
      end
   end

   // Busy-length tracker for the LAT=2 controller.
   int  b2_len;
   bit  b2_run;
   initial begin
      b2_len = 0; b2_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            b2_len = 0; b2_run = 0;
         end else if (busy_w[2]) begin
            if (!b2_run) b2_len = 0;
            b2_run = 1;
            b2_len++;
         end else begin
            b2_run = 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input int k);
      chk("rst_A", 32'(a_w[k]), 32'd0);
      chk("rst_B", 32'(b_w[k]), 32'd0);
      chk("rst_OP", 32'(op_w[k]), 32'd0);
      chk("rst_busy", 32'(busy_w[k]), 32'd0);
      chk("rst_done", 32'(done_w[k]), 32'd0);
      chk("rst_pass", 32'(pass_w[k]), 32'd0);
      chk("rst_err", 32'(err_w[k]), 32'd0);
      chk("rst_fail_vld", 32'(fvld_w[k]), 32'd0);
      chk("rst_fail_op", 32'(fop_w[k]), 32'd0);
      chk("rst_fail_y", 32'(fy_w[k]), 32'd0);
      chk("rst_fail_exp", 32'(fe_w[k]), 32'd0);
      chk("rst_sig", 32'(sig_w[k]), 32'd0);
   endtask

   task automatic check_aux();
      $display("aux: xor err=%0d fop=%0d fy=%02h fe=%02h | lat2 pass=%0d len=%0d | lat0-pipe pass=%0d",
               err_w[1], fop_w[1], fy_w[1], fe_w[1], pass_w[2], b2_len, pass_w[3]);
      chk("xor_done", 32'(done_w[1]), 32'd1);
      chk("xor_pass", 32'(pass_w[1]), 32'd0);
      chk("xor_err_cnt", 32'(err_w[1]), 32'(xerr_exp));
      chk("xor_fail_vld", 32'(fvld_w[1]), 32'd1);
      chk("xor_fail_op", 32'(fop_w[1]), 32'(xf_op));
      chk("xor_fail_y", 32'(fy_w[1]), 32'(xf_y));
      chk("xor_fail_exp", 32'(fe_w[1]), 32'(xf_exp));
      chk("lat2_done", 32'(done_w[2]), 32'd1);
      chk("lat2_pass", 32'(pass_w[2]), 32'd1);
      chk("lat2_err", 32'(err_w[2]), 32'd0);
      chk("lat2_run_len", 32'(b2_len), 32'(4 * NV * 4));
      chk("pipe_lat0_pass", 32'(pass_w[3]), 32'd0);
      chk("pipe_lat0_fail_vld", 32'(fvld_w[3]), 32'd1);
   endtask

   // One run: optional spurious start at busy cycle spur, optional reset at busy cycle rst_at.
   task automatic do_run(input int spur, input int rst_at);
      int cyc;
      push_model();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (cyc = 0; cyc < BOUND; cyc++) begin
         if (rst_at > 0 && cyc == rst_at) begin
            rst_n = 1'b0;
            #1;
            $display("reset asserted at run cycle %0d", cyc);
            for (int k = 0; k < NDUT; k++) check_zero(k);
            vec_q.delete();
            fin_q.delete();
            tick(2);
            rst_n = 1'b1;
            tick(1);
            return;
         end
         if (!(busy_w[0] | busy_w[1] | busy_w[2] | busy_w[3])) break;
         start = (spur > 0 && cyc == spur);
         tick(1);
      end
      start = 1'b0;
      chk("run_timeout", 32'(cyc < BOUND), 32'd1);
      tick(2);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      tick(3);
      for (int k = 0; k < NDUT; k++) check_zero(k);
      rst_n = 1'b1;
      tick(2);

      do_run(10, 0);
      check_aux();

      do_run(0, 40);
      do_run(0, 0);
      check_aux();

      for (int r = 0; r < 3; r++) begin
         tick($urandom_range(0, 15));
         do_run($urandom_range(2, 110), 0);
         check_aux();
      end

      do_run(0, $urandom_range(3, 120));
      do_run(0, 0);
      check_aux();

      chk("queue_drained", 32'(vec_q.size() + fin_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
